// File: rtl/cdr_pkg.sv
// Shared constants, vote type and arithmetic helpers for the CDR loop filter.
package cdr_pkg;

    localparam int CODE_MOD = 360;  // phase code modulus (degrees)
    localparam int CODE_W   = 9;    // phase code width
    localparam int FRAC_W   = 6;    // fractional phase bits below code LSB

    // Early/late decision of one vote window.
    typedef enum logic signed [1:0] {
        VOTE_DN   = 2'sb11,
        VOTE_NONE = 2'sb00,
        VOTE_UP   = 2'sb01
    } vote_t;

    // Vote as an integer step direction.
    function automatic int vote_val(input vote_t v);
        int r;
        case (v)
            VOTE_UP: r = 1;
            VOTE_DN: r = -1;
            default: r = 0;
        endcase
        return r;
    endfunction

    // Symmetric saturation to +/-lim.
    function automatic int sat_sym(input int v, input int lim);
        int r;
        if (v > lim)
            r = lim;
        else if (v < -lim)
            r = -lim;
        else
            r = v;
        return r;
    endfunction

    // Single-correction modulo; caller guarantees v is within one modulus of range.
    function automatic int wrap_mod(input int v, input int m);
        int r;
        if (v >= m)
            r = v - m;
        else if (v < 0)
            r = v + m;
        else
            r = v;
        return r;
    endfunction

endpackage

// File: rtl/cdr_vote_decim.sv
// Collapses DECIM bang-bang PD samples into one signed vote per window.
// vote and win_end are combinational on the last sample of a window so the
// filter can register its update on that same edge.
module cdr_vote_decim
    import cdr_pkg::*;
#(
    parameter int DECIM = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  freeze,
    input  logic  up,
    input  logic  dn,
    output vote_t vote,
    output logic  win_end
);

    localparam int CNT_W = $clog2(DECIM);
    localparam int SUM_W = $clog2(DECIM) + 2;

    logic        [CNT_W-1:0] win_cnt;
    logic signed [SUM_W-1:0] vote_sum;
    logic signed [SUM_W-1:0] d;
    logic signed [SUM_W-1:0] sum_next;

    // Per-sample vote, running sum including this sample, and window-end sign decision.
    always_comb begin
        d = '0;
        if (up && !dn)
            d = SUM_W'(1);
        else if (dn && !up)
            d = '1;
        sum_next = vote_sum + d;
        win_end  = !freeze && (win_cnt == CNT_W'(DECIM - 1));
        vote     = VOTE_NONE;
        if (sum_next[SUM_W-1])
            vote = VOTE_DN;
        else if (sum_next != '0)
            vote = VOTE_UP;
    end

    // Window counter and partial sum; both hold while frozen, clear at window end.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt  <= '0;
            vote_sum <= '0;
        end else if (!freeze) begin
            if (win_end) begin
                win_cnt  <= '0;
                vote_sum <= '0;
            end else begin
                win_cnt  <= win_cnt + 1'b1;
                vote_sum <= sum_next;
            end
        end
    end

endmodule

// File: rtl/cdr_loop_filter.sv
// CDR proportional + integral loop filter driving the interpolator phase code.
// Optional lock detector built when CDR_LOCK_DET_EN is defined; otherwise
// locked is tied low.
module cdr_loop_filter #(
    parameter int CODE_MOD = cdr_pkg::CODE_MOD,
    parameter int CODE_W   = cdr_pkg::CODE_W,
    parameter int FRAC_W   = cdr_pkg::FRAC_W,
    parameter int INT_W    = 12,
    parameter int DECIM    = 8,
    parameter int KP_STEP  = 64,
    parameter int KI_STEP  = 1,
    parameter int LOCK_CNT = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    up,
    input  logic                    dn,
    input  logic                    freeze,
    output logic [CODE_W-1:0]       code,
    output logic                    code_upd,
    output logic signed [INT_W-1:0] freq_int,
    output logic                    locked
);

    import cdr_pkg::*;

    localparam int PH_W   = CODE_W + FRAC_W;
    localparam int PH_MOD = CODE_MOD << FRAC_W;
    localparam int F_LIM  = 2 ** (INT_W - 1) - 1;

    // One wrap correction must always bring the phase back into range.
    if (KP_STEP + 2 ** (INT_W - 1) >= PH_MOD) begin : g_bad_gain
        $error("cdr_loop_filter: KP_STEP + 2^(INT_W-1) must be below CODE_MOD<<FRAC_W");
    end
    if (CODE_MOD > 2 ** CODE_W) begin : g_bad_mod
        $error("cdr_loop_filter: CODE_MOD does not fit in CODE_W");
    end

    vote_t vote;
    logic  win_end;

    logic [PH_W-1:0]         phase_acc;
    logic [PH_W-1:0]         phase_next;
    logic signed [INT_W-1:0] freq_next;
    logic [CODE_W-1:0]       code_next;
    int                      vi;
    int                      f_next_i;
    int                      p_next_i;

    cdr_vote_decim #(
        .DECIM (DECIM)
    ) u_decim (
        .clk     (clk),
        .rst     (rst),
        .freeze  (freeze),
        .up      (up),
        .dn      (dn),
        .vote    (vote),
        .win_end (win_end)
    );

    // Next integral (saturated) and next phase (wrapped into 0..PH_MOD-1).
    always_comb begin
        vi         = vote_val(vote);
        f_next_i   = sat_sym(int'(freq_int) + vi * KI_STEP, F_LIM);
        p_next_i   = wrap_mod(int'(phase_acc) + vi * KP_STEP + f_next_i, PH_MOD);
        freq_next  = INT_W'(f_next_i);
        phase_next = PH_W'(p_next_i);
        code_next  = phase_next[FRAC_W +: CODE_W];
    end

    assign code = phase_acc[FRAC_W +: CODE_W];

    // Filter state advances only on window ends; code_upd flags a new code value.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_acc <= '0;
            freq_int  <= '0;
            code_upd  <= 1'b0;
        end else begin
            code_upd <= 1'b0;
            if (win_end) begin
                phase_acc <= phase_next;
                freq_int  <= freq_next;
                code_upd  <= (code_next != code);
            end
        end
    end

`ifdef CDR_LOCK_DET_EN
    localparam int Q_W = $clog2(LOCK_CNT + 1);

    vote_t          prev_nz;
    logic [Q_W-1:0] quiet_cnt;
    logic [2:0]     run_len;
    logic           same;

    // A window is noisy only when it repeats the previous nonzero direction.
    always_comb begin
        same = (vote != VOTE_NONE) && (vote == prev_nz);
    end

    // Quiet windows build toward lock; a run of 4 same-sign votes drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_nz   <= VOTE_NONE;
            quiet_cnt <= '0;
            run_len   <= '0;
            locked    <= 1'b0;
        end else if (win_end) begin
            if (vote != VOTE_NONE)
                prev_nz <= vote;
            if (same) begin
                quiet_cnt <= '0;
                if (run_len != 3'd4)
                    run_len <= run_len + 3'd1;
                if (run_len >= 3'd3)
                    locked <= 1'b0;
            end else begin
                run_len <= (vote == VOTE_NONE) ? 3'd0 : 3'd1;
                if (quiet_cnt != Q_W'(LOCK_CNT))
                    quiet_cnt <= quiet_cnt + 1'b1;
                if (quiet_cnt >= Q_W'(LOCK_CNT - 1))
                    locked <= 1'b1;
            end
        end
    end
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_cdr_loop_filter.sv
// Directed bench for cdr_loop_filter. dut_a has no integral path (KI_STEP=0)
// for exact proportional-step checks; dut_b uses KI_STEP=16 so the 12-bit
// integral saturates inside 200 windows.
module tb_cdr_loop_filter;

`ifdef CDR_LOCK_DET_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, up, dn, freeze;
    logic [8:0]         code_a, code_b;
    logic               upd_a, upd_b;
    logic signed [11:0] freq_a, freq_b;
    logic               lock_a, lock_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cdr_loop_filter #(.KI_STEP(0)) dut_a (
        .clk(clk), .rst(rst), .up(up), .dn(dn), .freeze(freeze),
        .code(code_a), .code_upd(upd_a), .freq_int(freq_a), .locked(lock_a)
    );

    cdr_loop_filter #(.KI_STEP(16)) dut_b (
        .clk(clk), .rst(rst), .up(up), .dn(dn), .freeze(freeze),
        .code(code_b), .code_upd(upd_b), .freq_int(freq_b), .locked(lock_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; up = 1'b0; dn = 1'b0; freeze = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic drive_window(input logic u, input logic d);
        up = u; dn = d;
        repeat (8) step();
        up = 1'b0; dn = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; up = 1'b1; dn = 1'b0; freeze = 1'b0;
        repeat (3) step();
        checks++;
        if (code_a !== 9'd0 || upd_a !== 1'b0) begin
            failures++; $display("FAIL reset_code_a: got code=%0d upd=%0b want 0/0", code_a, upd_a);
        end
        checks++;
        if (freq_a !== 12'sd0 || freq_b !== 12'sd0) begin
            failures++; $display("FAIL reset_freq: got a=%0d b=%0d want 0", freq_a, freq_b);
        end
        checks++;
        if (lock_a !== 1'b0 || lock_b !== 1'b0) begin
            failures++; $display("FAIL reset_locked: got a=%0b b=%0b want 0", lock_a, lock_b);
        end
        rst = 1'b0; up = 1'b0;
        repeat (16) step();
        checks++;
        if (code_a !== 9'd0 || code_b !== 9'd0 || freq_b !== 12'sd0 || lock_a !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got code_a=%0d code_b=%0d freq_b=%0d lock=%0b want 0", code_a, code_b, freq_b, lock_a);
        end
    endtask

    task automatic test_up_step();
        logic [8:0] exp_c;
        logic       exp_u;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            up = 1'b1;
            step();
            exp_c = (i == 7) ? 9'd1 : 9'd0;
            exp_u = (i == 7);
            checks++;
            if (code_a !== exp_c || upd_a !== exp_u) begin
                failures++;
                $display("FAIL up_step[%0d]: got code=%0d upd=%0b want %0d/%0b", i, code_a, upd_a, exp_c, exp_u);
            end
        end
        up = 1'b0;
        step();
        checks++;
        if (code_a !== 9'd1 || upd_a !== 1'b0) begin
            failures++; $display("FAIL up_step_hold: got code=%0d upd=%0b want 1/0", code_a, upd_a);
        end
    endtask

    task automatic test_dn_wrap();
        do_reset();
        drive_window(1'b0, 1'b1);
        checks++;
        if (code_a !== 9'd359 || upd_a !== 1'b1 || freq_a !== 12'sd0) begin
            failures++;
            $display("FAIL wrap_down: got code=%0d upd=%0b freq=%0d want 359/1/0", code_a, upd_a, freq_a);
        end
        drive_window(1'b1, 1'b0);
        checks++;
        if (code_a !== 9'd0 || upd_a !== 1'b1) begin
            failures++; $display("FAIL wrap_up: got code=%0d upd=%0b want 0/1", code_a, upd_a);
        end
    endtask

    task automatic test_both_votes();
        int bad;
        do_reset();
        drive_window(1'b1, 1'b0);
        // dut_b after one up window: freq=16, phase=64+16=80 -> code 1
        up = 1'b1; dn = 1'b1;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            checks++;
            if (code_a !== 9'd1 || upd_a !== 1'b0) begin
                failures++; bad++;
                if (bad < 4) $display("FAIL both_votes[%0d]: got code=%0d upd=%0b want 1/0", i, code_a, upd_a);
            end
        end
        up = 1'b0; dn = 1'b0;
        // 8 zero-vote windows keep drifting by freq: 80+8*16=208 -> code 3
        checks++;
        if (code_b !== 9'd3 || freq_b !== 12'sd16) begin
            failures++; $display("FAIL drift_zero_vote: got code=%0d freq=%0d want 3/16", code_b, freq_b);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        up = 1'b1;
        repeat (7) step();
        freeze = 1'b1;
        repeat (5) step();
        checks++;
        if (code_a !== 9'd0 || upd_a !== 1'b0 || freq_b !== 12'sd0) begin
            failures++;
            $display("FAIL freeze_hold: got code=%0d upd=%0b freq_b=%0d want 0/0/0", code_a, upd_a, freq_b);
        end
        freeze = 1'b0;
        step();
        checks++;
        if (code_a !== 9'd1 || upd_a !== 1'b1) begin
            failures++; $display("FAIL freeze_resume: got code=%0d upd=%0b want 1/1", code_a, upd_a);
        end
        up = 1'b0;
    endtask

    task automatic test_integral();
        int f;
        int p;
        int wraps;
        do_reset();
        f = 0; p = 0; wraps = 0;
        for (int w = 0; w < 200; w++) begin
            drive_window(1'b1, 1'b0);
            f = (f + 16 > 2047) ? 2047 : f + 16;
            p = p + 64 + f;
            if (p >= 360 * 64) begin
                p = p - 360 * 64;
                wraps++;
            end
            checks++;
            if (code_b !== 9'(p / 64) || freq_b !== 12'(f)) begin
                failures++;
                $display("FAIL integral_w%0d: got code=%0d freq=%0d want %0d/%0d", w, code_b, freq_b, p / 64, f);
            end
        end
        checks++;
        if (freq_b !== 12'sd2047 || wraps < 5) begin
            failures++; $display("FAIL integral_sat: got freq=%0d wraps=%0d want 2047/>=5", freq_b, wraps);
        end
        checks++;
        if (code_a !== 9'd200) begin
            failures++; $display("FAIL prop_200: got code=%0d want 200", code_a);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        up = 1'b1;
        repeat (5) step();
        rst = 1'b1; up = 1'b0;
        step();
        rst = 1'b0; up = 1'b1;
        repeat (7) step();
        checks++;
        if (code_a !== 9'd0) begin
            failures++; $display("FAIL reset_mid_partial: got code=%0d want 0", code_a);
        end
        step();
        checks++;
        if (code_a !== 9'd1 || upd_a !== 1'b1) begin
            failures++; $display("FAIL reset_mid_full: got code=%0d upd=%0b want 1/1", code_a, upd_a);
        end
        up = 1'b0;
    endtask

    task automatic test_lock();
        logic exp_l;
        do_reset();
        for (int w = 0; w < 36; w++) begin
            drive_window(w % 2 == 0, w % 2 == 1);
            exp_l = LOCK_EN && (w >= 31);
            checks++;
            if (lock_a !== exp_l) begin
                failures++; $display("FAIL lock_alt_w%0d: got %0b want %0b", w, lock_a, exp_l);
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive_window(1'b1, 1'b0);
            exp_l = LOCK_EN && (k < 3);
            checks++;
            if (lock_a !== exp_l) begin
                failures++; $display("FAIL lock_same_k%0d: got %0b want %0b", k, lock_a, exp_l);
            end
        end
    endtask

    initial begin
        rst = 1'b1; up = 1'b0; dn = 1'b0; freeze = 1'b0;
        test_reset();
        test_up_step();
        test_dn_wrap();
        test_both_votes();
        test_freeze();
        test_integral();
        test_reset_mid();
        test_lock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
